mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the shared-memory port of mem_arbiter.
// The arbiter connects through the slave modport; the requesters and memory connect through master.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    // instruction port
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 ack1;
    // data port
    logic                 readM2;
    logic                 writeM2;
    logic [WORD_SIZE-1:0] address2;
    logic [WORD_SIZE-1:0] wdata2;
    logic [WORD_SIZE-1:0] rdata2;
    logic                 ack2;
    // shared memory
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    // status
    logic                 busy;

    modport slave (
        input  readM1, address1, readM2, writeM2, address2, wdata2, mem_rdata,
        output data1, ack1, rdata2, ack2, mem_read, mem_write, mem_address, mem_wdata, busy
    );

    modport master (
        output readM1, address1, readM2, writeM2, address2, wdata2, mem_rdata,
        input  data1, ack1, rdata2, ack2, mem_read, mem_write, mem_address, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single shared memory: data port normally wins,
// instruction port wins once it has been passed over STARVE_LIMIT times in a row.
// Each access holds its strobe for MEM_LATENCY cycles, then acks for one cycle.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

    state_t               state;
    state_t               state_next;
    logic [3:0]           lat_cnt;
    logic [3:0]           starve_cnt;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] data1_q;
    logic [WORD_SIZE-1:0] rdata2_q;
    logic                 write_q;
    logic                 data_req;
    logic                 grant_i;
    logic                 grant_d;
    logic                 last_beat;
    logic                 in_busy;

    // Arbitration decision, only meaningful while IDLE
    always_comb begin
        data_req  = bus.readM2 | bus.writeM2;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        in_busy   = (state == BUSY_I) || (state == BUSY_D);
        last_beat = (lat_cnt == 4'(MEM_LATENCY - 1));
        if (state == IDLE) begin
            if (bus.readM1 && (!data_req || starve_cnt == 4'(STARVE_LIMIT))) begin
                grant_i = 1'b1;
            end else if (data_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next = BUSY_I;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I:  if (last_beat) state_next = DONE_I;
            BUSY_D:  if (last_beat) state_next = DONE_D;
            DONE_I:  state_next = IDLE;
            DONE_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: strobes, bus values and acks derived from state
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.ack1        = 1'b0;
        bus.ack2        = 1'b0;
        bus.busy        = (state != IDLE);
        bus.data1       = data1_q;
        bus.rdata2      = rdata2_q;
        unique case (state)
            BUSY_I: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_q;
            end
            BUSY_D: begin
                bus.mem_address = addr_q;
                if (write_q) begin
                    bus.mem_write = 1'b1;
                    bus.mem_wdata = wdata_q;
                end else begin
                    bus.mem_read = 1'b1;
                end
            end
            DONE_I:  bus.ack1 = 1'b1;
            DONE_D:  bus.ack2 = 1'b1;
            default: ;
        endcase
    end

    // Strobe-length counter, restarted for every access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (in_busy && !last_beat) begin
            lat_cnt <= lat_cnt + 4'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    // Latch the granted request; requester inputs are ignored until the access completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (grant_i) begin
            addr_q  <= bus.address1;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= bus.address2;
            wdata_q <= bus.wdata2;
            write_q <= bus.writeM2;
        end
    end

    // Capture read data in the last strobe cycle; held until the next read on that port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1_q  <= '0;
            rdata2_q <= '0;
        end else if (last_beat) begin
            if (state == BUSY_I) begin
                data1_q <= bus.mem_rdata;
            end else if (state == BUSY_D && !write_q) begin
                rdata2_q <= bus.mem_rdata;
            end
        end
    end

    // Count data grants that passed over a waiting instruction request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!bus.readM1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule
